// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. A
//   round-robin arbiter picks one requester in IDLE and latches its operands
//   and opcode. The latched values drive the ALU for the whole operation. The
//   ALU result and compare flags are captured, then held on a shared response
//   bus. The granted requester consumes them with a valid/ready handshake.
//   This block does no arithmetic: opcodes and results pass through as-is.
//
// Configuration:
//   ALU_ARB_RESULT_REG_EN -- when defined, a WAIT state is inserted between
//   EXEC and RESP. The ALU result is then captured at the end of WAIT, so the
//   ALU has a two-cycle settling window. When undefined, the result is captured
//   at the end of EXEC.
//
// Parameters:
//   DW   operand / result width
//   OPW  opcode width
//
// Ports:
//   clk                  single clock, rising edge
//   rst_n                synchronous active-low reset
//   req0_valid/ready     request handshake, requester 0
//   req0_a/b, req0_op    requester 0 operands and opcode
//   req1_*               same for requester 1
//   rsp0_valid/ready     response handshake, requester 0
//   rsp1_valid/ready     response handshake, requester 1
//   rsp_out, rsp_comp    shared result and compare-flag bus
//   alu_a/b, alu_op      operands and opcode to the ALU
//   alu_out, alu_comp    result and compare flags from the ALU (combinational)
//   busy                 high in every state except IDLE
//   grant_id             requester currently owning the ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DW  = 16,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,

   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic [OPW-1:0] req0_op,

   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   input  logic [OPW-1:0] req1_op,

   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [DW-1:0]  rsp_out,
   output logic [2:0]     rsp_comp,

   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [DW-1:0]  alu_out,
   input  logic [2:0]     alu_comp,

   output logic           busy,
   output logic           grant_id
);

   // FSM encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
`ifdef ALU_ARB_RESULT_REG_EN
   localparam logic [1:0] WAIT = 2'd3;
`endif

   // State and datapath registers
   logic [1:0]     r_state;
   logic           r_last_grant;
   logic           r_grant_id;
   logic [DW-1:0]  r_a;
   logic [DW-1:0]  r_b;
   logic [OPW-1:0] r_op;
   logic [DW-1:0]  r_rsp_out;
   logic [2:0]     r_rsp_comp;

   // Combinational decode
   logic           w_idle;
   logic           w_take0;
   logic           w_take1;
   logic           w_xfer;
   logic           w_rsp_done;
   logic           w_capture;
   logic [1:0]     w_next_state;

   assign w_idle = (r_state == IDLE);

   // Round-robin selection. A lone valid requester always wins. When both are
   // valid, the requester that was not granted last time wins. w_take0 and
   // w_take1 are mutually exclusive by construction.
   assign w_take0 = req0_valid & (~req1_valid | r_last_grant);
   assign w_take1 = req1_valid & (~req0_valid | ~r_last_grant);

   // Readies are gated by rst_n, so nothing is accepted while reset is held.
   // The edge that samples rst_n=0 must not also latch a transfer.
   assign req0_ready = rst_n & w_idle & w_take0;
   assign req1_ready = rst_n & w_idle & w_take1;
   assign w_xfer     = req0_ready | req1_ready;

   // Only the granted requester's rsp_ready completes the response. The other
   // requester's rsp_ready is ignored.
   assign w_rsp_done = r_grant_id ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_RESULT_REG_EN
   assign w_capture = (r_state == WAIT);
`else
   assign w_capture = (r_state == EXEC);
`endif

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so that every path assigns
      // w_next_state; an incomplete assignment here would infer a latch.
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_xfer) w_next_state = EXEC;
         end
`ifdef ALU_ARB_RESULT_REG_EN
         EXEC:    w_next_state = WAIT;
         WAIT:    w_next_state = RESP;
`else
         EXEC:    w_next_state = RESP;
`endif
         RESP: begin
            // Requests are only evaluated in IDLE, never in the completing
            // RESP cycle.
            if (w_rsp_done) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Sequential state
   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;      // requester 0 wins the first contention
         r_grant_id   <= 1'b0;
         // NOTE: the operand and result holding registers are a handful of
         // flops, not a RAM. They are reset so that the ALU inputs and the
         // response bus come up at a defined zero.
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_rsp_out    <= '0;
         r_rsp_comp   <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_xfer) begin
            r_grant_id   <= w_take1;
            r_last_grant <= w_take1;
            r_a          <= w_take1 ? req1_a  : req0_a;
            r_b          <= w_take1 ? req1_b  : req0_b;
            r_op         <= w_take1 ? req1_op : req0_op;
         end

         if (w_capture) begin
            r_rsp_out  <= alu_out;
            r_rsp_comp <= alu_comp;
         end
      end
   end

   // Outputs
   // The ALU is always fed from the latched registers, so its inputs are
   // stable for the whole operation, whatever the requesters do meanwhile.
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_op     = r_op;

   assign rsp_out    = r_rsp_out;
   assign rsp_comp   = r_rsp_comp;
   assign rsp0_valid = (r_state == RESP) & ~r_grant_id;
   assign rsp1_valid = (r_state == RESP) &  r_grant_id;

   assign busy       = ~w_idle;
   assign grant_id   = r_grant_id;

endmodule
